bsg_fsb_murn_deser: RTL and testbench

//  Upstream feeder for the FSB murn gateway. Collects narrow chunks from a

---
 rtl/bsg_fsb_murn_deser_if.sv | 34 +++
 rtl/bsg_fsb_murn_deser.sv | 96 +++++++++
 tb/tb_bsg_fsb_murn_deser.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fsb_murn_deser_if.sv
// Link-side beat channel plus gateway-side packet channel of the deser.
// slave = deser side, master = feeder/consumer side.
interface bsg_fsb_murn_deser_if #(
  parameter int chunk_width_p = 4,
  parameter int ring_width_p  = 16
);
  logic                     v_i;
  logic                     sof_i;
  logic [chunk_width_p-1:0] data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [ring_width_p-1:0]  data_o;
  logic                     ready_i;

  modport slave (
    input  v_i,
    input  sof_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output v_o,
    output data_o
  );

  modport master (
    output v_i,
    output sof_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  v_o,
    input  data_o
  );
endinterface

// File: rtl/bsg_fsb_murn_deser.sv
// Assembles little-endian chunk beats into ring-width FSB packets,
// with framing-error detection and a saturating error counter.
module bsg_fsb_murn_deser #(
  parameter int chunk_width_p = 4,
  parameter int ring_width_p  = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bsg_fsb_murn_deser_if.slave        link,
  output logic                       frame_err_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int beats_lp = ring_width_p / chunk_width_p;
  localparam int cnt_w_lp = (beats_lp > 2) ? $clog2(beats_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(beats_lp - 1);

  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic [ring_width_p-1:0] asm_q, asm_d;
  logic                    v_o_q, v_o_d;
  logic [ring_width_p-1:0] data_o_q, data_o_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic ready_w;
  logic accept_w;
  logic at_last_w;

  // Only the final beat can stall: it needs the output register free.
  always_comb begin
    at_last_w = (cnt_q == last_lp);
    ready_w   = !at_last_w || !v_o_q || link.ready_i;
    accept_w  = link.v_i && ready_w;
  end

  // Framing, packing and output-register next state.
  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    v_o_d     = v_o_q && !link.ready_i;
    data_o_d  = data_o_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (accept_w) begin
      if (link.sof_i) begin
        // A sof mid-packet restarts assembly and flags the lost partial.
        if (cnt_q != '0) begin
          err_d = 1'b1;
        end
        asm_d                    = '0;
        asm_d[chunk_width_p-1:0] = link.data_i;
        cnt_d                    = cnt_w_lp'(1);
      end else if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        asm_d[int'(cnt_q)*chunk_width_p +: chunk_width_p] = link.data_i;
        if (at_last_w) begin
          v_o_d    = 1'b1;
          data_o_d = asm_d;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
    end
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      v_o_q     <= 1'b0;
      data_o_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      v_o_q     <= v_o_d;
      data_o_q  <= data_o_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign link.ready_o = ready_w;
  assign link.v_o     = v_o_q;
  assign link.data_o  = data_o_q;
  assign frame_err_o  = err_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_bsg_fsb_murn_deser.sv
// Scoreboard bench for bsg_fsb_murn_deser: queue-based packet model,
// directed framing scenarios and a randomized soak.
module tb_bsg_fsb_murn_deser;

  localparam int CW = 4;
  localparam int RW = 16;
  localparam int NB = RW / CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  bsg_fsb_murn_deser_if #(.chunk_width_p(CW), .ring_width_p(RW)) link();

  bsg_fsb_murn_deser #(.chunk_width_p(CW), .ring_width_p(RW)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .link        (link),
    .frame_err_o (frame_err),
    .err_cnt_o   (err_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  logic [CW-1:0] part[$];
  int model_errs = 0;
  int pulse_cnt = 0;
  int ready_mode = 0;

  logic          held_v = 1'b0;
  logic [RW-1:0] held_d = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: frames are lists of beats; a full list becomes one packet.
  task automatic model_beat(input bit sof, input logic [CW-1:0] d);
    logic [RW-1:0] pkt;
    if (sof) begin
      if (part.size() != 0) model_errs++;
      part.delete();
      part.push_back(d);
    end else if (part.size() == 0) begin
      model_errs++;
    end else begin
      part.push_back(d);
      if (part.size() == NB) begin
        pkt = '0;
        for (int k = 0; k < NB; k++) pkt = pkt + (RW'(part[k]) << (CW * k));
        exp_q.push_back(pkt);
        part.delete();
      end
    end
  endtask

  // Drive a beat and hold it until the handshake completes.
  task automatic send_beat(input bit sof, input logic [CW-1:0] d);
    bit done;
    done = 1'b0;
    link.v_i = 1'b1;
    link.sof_i = sof;
    link.data_i = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (link.ready_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    link.v_i = 1'b0;
    if (done) begin
      model_beat(sof, d);
    end else begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got ready_o=0 for 200 cycles expected 1");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    link.v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    part.delete();
    model_errs = 0;
    pulse_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string name);
    int sat;
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    sat = (model_errs > 255) ? 255 : model_errs;
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_v_o"}, {31'd0, link.v_o}, 0);
    chk({name, "_err_cnt"}, {24'd0, err_cnt}, sat);
    chk({name, "_pulses"}, pulse_cnt, model_errs);
    @(posedge clk);
    #1;
  endtask

  // Downstream readiness: always, never, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: link.ready_i = 1'b1;
      1: link.ready_i = 1'b0;
      default: link.ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pop expected packets on transfers, check hold and pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (frame_err) pulse_cnt++;
      if (link.v_o) begin
        if (held_v) chk("hold_stable", {16'd0, link.data_o}, {16'd0, held_d});
        if (link.ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pkt", {16'd0, link.data_o}, 32'hDEAD0000);
          end else begin
            chk("pkt_data", {16'd0, link.data_o}, {16'd0, exp_q.pop_front()});
          end
        end
      end
      held_v = link.v_o && !link.ready_i;
      held_d = link.data_o;
    end
  end

  initial begin
    int pos;
    bit sof;
    link.v_i = 1'b0;
    link.sof_i = 1'b0;
    link.data_i = '0;
    link.ready_i = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_v_o", {31'd0, link.v_o}, 0);
    chk("rst_data_o", {16'd0, link.data_o}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    @(posedge clk);
    #1;

    // Basic packet with one-cycle latency.
    send_beat(1, 4'h1);
    send_beat(0, 4'h2);
    send_beat(0, 4'h3);
    send_beat(0, 4'h4);
    @(negedge clk);
    chk("t1_v_o", {31'd0, link.v_o}, 1);
    chk("t1_data", {16'd0, link.data_o}, 32'h4321);
    @(negedge clk);
    chk("t1_v_o_drop", {31'd0, link.v_o}, 0);
    @(posedge clk);
    #1;
    check_idle("t1");

    // Backpressure on the final beat of the second packet.
    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 7; i++) send_beat(i == 1 || i == 5, CW'(i));
    link.v_i = 1'b1;
    link.sof_i = 1'b0;
    link.data_i = 4'h8;
    @(negedge clk);
    chk("t2_ready_o", {31'd0, link.ready_o}, 0);
    chk("t2_held", {16'd0, link.data_o}, 32'h4321);
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_beat(0, 4'h8);
    check_idle("t2");

    // Stray beat at cnt==0.
    send_beat(0, 4'h5);
    check_idle("t3");

    // Truncated frame followed by a good one.
    send_beat(1, 4'hA);
    send_beat(0, 4'hB);
    for (int i = 1; i <= 4; i++) send_beat(i == 1, CW'(i));
    check_idle("t4");

    // Reset discards a held packet and a partial one.
    ready_mode = 1;
    for (int i = 9; i <= 12; i++) send_beat(i == 9, CW'(i));
    send_beat(1, 4'h1);
    send_beat(0, 4'h2);
    do_reset();
    @(negedge clk);
    chk("t5_v_o", {31'd0, link.v_o}, 0);
    chk("t5_err_cnt", {24'd0, err_cnt}, 0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 5; i <= 8; i++) send_beat(i == 5, CW'(i));
    check_idle("t5");

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send_beat(0, CW'($urandom));
    check_idle("t6");

    // Randomized soak with rare framing faults and random backpressure.
    ready_mode = 2;
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      sof = (pos == 0);
      if ($urandom_range(0, 15) == 0) sof = !sof;
      pos = (pos + 1) % NB;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_beat(sof, CW'($urandom));
    end
    check_idle("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
